// File: rtl/traffic_pkg.sv
// Shared traffic-light types and constants: timer state encoding, counter
// width and the phase durations the phase FSM drives onto load_val.
package traffic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int unsigned COUNT_W = 6;

  localparam logic [COUNT_W-1:0] GREEN_T  = 6'd30;
  localparam logic [COUNT_W-1:0] YELLOW_T = 6'd5;
  localparam logic [COUNT_W-1:0] RED_T    = 6'd25;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the phase FSM (master) and the countdown
// timer (slave). Clock and reset stay plain ports on the timer.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 6
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             tick;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, tick, hold, abort,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, tick, hold, abort,
    output count, busy, done
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter timing one traffic-light phase. Counts down once per
// enabled tick and emits a one-cycle done pulse on reaching zero.
module countdown_timer
  import traffic_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  timer_state_t     state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             done_q, done_n;

  // State, count and done registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic: abort beats start, start beats tick/hold.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    done_n  = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      count_n = '0;
    end else if (bus.start) begin
      if (bus.load_val != '0) begin
        state_n = RUN;
        count_n = bus.load_val;
      end else begin
        // Zero-length phase completes immediately.
        state_n = IDLE;
        count_n = '0;
        done_n  = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (bus.tick && !bus.hold) begin
        if (count_q <= WIDTH'(1)) begin
          state_n = IDLE;
          count_n = '0;
          done_n  = 1'b1;
        end else begin
          count_n = count_q - WIDTH'(1);
        end
      end
    end else begin
      count_n = '0;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;

endmodule
